mult_share_arbiter: RTL and testbench

//  Shares one combinational WIDTHxWIDTH unsigned multiplier between two requesters.

---
 rtl/mult_share_arbiter.sv | 61 ++++++
 tb/tb_mult_share_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin share of one combinational multiplier between two
// valid/ready requesters, with a registered product on one valid/ready response port.
module mult_share_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_product
);
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic               last_q, last_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               can_issue, any_req, gnt, issue, accept;
  // on a tie the channel that did not win last time goes next
  always_comb begin
    can_issue = !rsp_valid_q || rsp_ready;
    any_req   = req0_valid || req1_valid;
    gnt       = (req0_valid && req1_valid) ? !last_q : req1_valid;
    issue     = can_issue && any_req;
    accept    = issue && !rst;
    req0_ready = accept && !gnt;
    req1_ready = accept && gnt;
    mul_a = issue ? (gnt ? req1_a : req0_a) : '0;
    mul_b = issue ? (gnt ? req1_b : req0_b) : '0;
    rsp_valid_d = accept ? 1'b1 : (rsp_ready ? 1'b0 : rsp_valid_q);
    rsp_id_d    = accept ? gnt : rsp_id_q;
    prod_d      = accept ? mul_result : prod_q;
    last_d      = accept ? gnt : last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      prod_q      <= '0;
      last_q      <= 1'b1;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      prod_q      <= prod_d;
      last_q      <= last_d;
    end
  end
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = prod_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed vector table for mult_share_arbiter with a behavioural
// multiplier; each row checks same-cycle handshake/operands and the registered response.
module tb_mult_share_arbiter;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, mul_a, mul_b;
  logic [2*W-1:0] mul_result, rsp_product;
  logic rsp_valid, rsp_ready, rsp_id;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign mul_result = mul_a * mul_b;

  mult_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_product(rsp_product)
  );

  typedef struct {
    int rst, v0, a0, b0, v1, a1, b1, rr;
    int r0, r1, ma, mb;
    int rv, id, p;
  } vec_t;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s vec %0d got %0d want %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst        = t.rst != 0;
    req0_valid = t.v0 != 0;
    req0_a     = W'(t.a0);
    req0_b     = W'(t.b0);
    req1_valid = t.v1 != 0;
    req1_a     = W'(t.a1);
    req1_b     = W'(t.b1);
    rsp_ready  = t.rr != 0;
  endtask

  vec_t v[25];

  initial begin
    //      rst v0 a0 b0 v1 a1 b1 rr | r0 r1 ma mb | rv id p
    v = '{
      '{0, 1,  3, 5, 0, 0, 0, 1,  1, 0,  3,  5,  1, 0,  15},
      '{0, 1, 15,15, 1, 2, 7, 1,  0, 1,  2,  7,  1, 1,  14},
      '{0, 1, 15,15, 1, 2, 7, 1,  1, 0, 15, 15,  1, 0, 225},
      '{0, 1, 15,15, 1, 2, 7, 1,  0, 1,  2,  7,  1, 1,  14},
      '{0, 1, 15,15, 1, 2, 7, 1,  1, 0, 15, 15,  1, 0, 225},
      '{0, 1, 15,15, 1, 2, 7, 0,  0, 0,  0,  0,  1, 0, 225},
      '{0, 1, 15,15, 1, 2, 7, 0,  0, 0,  0,  0,  1, 0, 225},
      '{0, 1, 15,15, 1, 2, 7, 0,  0, 0,  0,  0,  1, 0, 225},
      '{0, 1, 15,15, 1, 2, 7, 1,  0, 1,  2,  7,  1, 1,  14},
      '{0, 0,  0, 0, 1, 3, 4, 1,  0, 1,  3,  4,  1, 1,  12},
      '{0, 0,  0, 0, 1, 3, 4, 1,  0, 1,  3,  4,  1, 1,  12},
      '{0, 0,  0, 0, 1, 3, 4, 1,  0, 1,  3,  4,  1, 1,  12},
      '{0, 1, 15,15, 1, 3, 4, 1,  1, 0, 15, 15,  1, 0, 225},
      '{0, 0,  0, 0, 0, 0, 0, 1,  0, 0,  0,  0,  0, 0, 225},
      '{0, 0,  0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0, 0, 225},
      '{0, 0,  0, 0, 1, 3, 4, 1,  0, 1,  3,  4,  1, 1,  12},
      '{0, 1, 15,15, 0, 0, 0, 1,  1, 0, 15, 15,  1, 0, 225},
      '{1, 1, 15,15, 1, 2, 7, 0,  0, 0,  0,  0,  0, 0,   0},
      '{0, 1, 15,15, 1, 2, 7, 1,  1, 0, 15, 15,  1, 0, 225},
      '{0, 1,  0,15, 0, 0, 0, 1,  1, 0,  0, 15,  1, 0,   0},
      '{0, 0,  0, 0, 1,15, 1, 1,  0, 1, 15,  1,  1, 1,  15},
      '{0, 1,  8, 8, 0, 0, 0, 1,  1, 0,  8,  8,  1, 0,  64},
      '{0, 0,  0, 0, 0, 0, 0, 1,  0, 0,  0,  0,  0, 0,  64},
      '{0, 0,  0, 0, 1, 2, 7, 0,  0, 1,  2,  7,  1, 1,  14},
      '{0, 0,  0, 0, 1, 2, 7, 0,  0, 0,  0,  0,  1, 1,  14}
    };
    rst = 1'b1; req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd7; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy0", -1, int'(req0_ready), 0);
    chk("rst_rdy1", -1, int'(req1_ready), 0);
    chk("rst_valid", -1, int'(rsp_valid), 0);
    chk("rst_id", -1, int'(rsp_id), 0);
    chk("rst_product", -1, int'(rsp_product), 0);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive(v[i]);
      #1;
      chk("rdy0", i, int'(req0_ready), v[i].r0);
      chk("rdy1", i, int'(req1_ready), v[i].r1);
      chk("mul_a", i, int'(mul_a), v[i].ma);
      chk("mul_b", i, int'(mul_b), v[i].mb);
      @(posedge clk);
      #1;
      chk("rsp_valid", i, int'(rsp_valid), v[i].rv);
      chk("rsp_id", i, int'(rsp_id), v[i].id);
      chk("rsp_product", i, int'(rsp_product), v[i].p);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
